// File: rtl/comp_arb_pipe.sv
// comp_arb_pipe: round-robin merge of CHANNELS valid/ready inputs into a
// DEPTH-entry FIFO whose head drives a channel-tagged valid/ready output.
// Optional build macro COMP_ARB_PIPE_STATS_EN adds io_stall_cycles, a
// saturating 16-bit count of cycles where a producer was valid but no
// channel was granted.
module comp_arb_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DEPTH    = 2,
   // derived widths; leave at their defaults
   parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int unsigned NW       = $clog2(DEPTH + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] io_in_data,
   input  logic [CHANNELS-1:0]       io_in_valid,
   output logic [CHANNELS-1:0]       io_in_ready,
   output logic [WIDTH-1:0]          io_out_data,
   output logic [CW-1:0]             io_out_chan,
   output logic                      io_out_valid,
   input  logic                      io_out_ready,
   output logic [NW-1:0]             io_count
`ifdef COMP_ARB_PIPE_STATS_EN
   ,
   output logic [15:0]               io_stall_cycles
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned EW = CW + WIDTH;

   // FIFO state
   logic [EW-1:0]       mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [NW-1:0]       count;

   // arbiter state and decode
   logic [CW-1:0]       last_grant;
   logic [CW-1:0]       idx_hi;
   logic [CW-1:0]       idx_lo;
   logic                found_hi;
   logic                found_lo;
   logic [CW-1:0]       gnt_idx;
   logic                gnt_found;
   logic [CHANNELS-1:0] grant_oh;
   logic [WIDTH-1:0]    in_word;
   logic                not_full;
   logic                push;
   logic                pop;

   // Round-robin search: first valid channel above last_grant, else first
   // valid channel at or below it (the wrap-around half).
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (!found_hi && io_in_valid[i] && (i > int'(last_grant))) begin
            found_hi = 1'b1;
            idx_hi   = CW'(i);
         end
         if (!found_lo && io_in_valid[i] && (i <= int'(last_grant))) begin
            found_lo = 1'b1;
            idx_lo   = CW'(i);
         end
      end
      gnt_found = found_hi | found_lo;
      gnt_idx   = found_hi ? idx_hi : idx_lo;
   end

   // One-hot grant and data select for the granted channel
   always_comb begin
      grant_oh = '0;
      in_word  = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (gnt_found && (gnt_idx == CW'(i))) begin
            grant_oh[i] = 1'b1;
            in_word     = io_in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Ready only when there is room; a pop in the same cycle does not open a slot
   assign not_full     = (count < NW'(DEPTH));
   assign io_in_ready  = (!reset && not_full) ? grant_oh : '0;
   assign push         = |(io_in_valid & io_in_ready);
   assign pop          = io_out_valid & io_out_ready;

   assign io_out_valid = (count != '0);
   assign io_count     = count;
   assign {io_out_chan, io_out_data} = mem[rd_ptr];

   // FIFO storage: write {chan, data} at the write pointer on a push
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {gnt_idx, in_word};
      end
   end

   // Pointers and occupancy; push+pop together leaves count unchanged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   // Last granted channel moves only on an accepted input word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= CW'(CHANNELS - 1);
      end else if (push) begin
         last_grant <= gnt_idx;
      end
   end

`ifdef COMP_ARB_PIPE_STATS_EN
   logic stall_c;

   assign stall_c = (|io_in_valid) && (io_in_ready == '0);

   // Saturating count of cycles where some producer waited without a grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_stall_cycles <= '0;
      end else if (stall_c && (io_stall_cycles != 16'hFFFF)) begin
         io_stall_cycles <= io_stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_comp_arb_pipe.sv
// Directed bench for comp_arb_pipe (WIDTH=8, CHANNELS=3, DEPTH=2) with a
// queue-based scoreboard drained by an output monitor.
module tb_comp_arb_pipe;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 3;
   localparam int unsigned DEPTH    = 2;
   localparam int unsigned CW       = 2;
   localparam int unsigned NW       = 2;

   typedef struct packed {
      logic [CW-1:0]    chan;
      logic [WIDTH-1:0] data;
   } word_t;

   logic                      clock;
   logic                      reset;
   logic [CHANNELS*WIDTH-1:0] io_in_data;
   logic [CHANNELS-1:0]       io_in_valid;
   logic [CHANNELS-1:0]       io_in_ready;
   logic [WIDTH-1:0]          io_out_data;
   logic [CW-1:0]             io_out_chan;
   logic                      io_out_valid;
   logic                      io_out_ready;
   logic [NW-1:0]             io_count;
`ifdef COMP_ARB_PIPE_STATS_EN
   logic [15:0]               io_stall_cycles;
`endif

   int    checks = 0;
   int    errors = 0;
   word_t exp_q[$];
   word_t mon_e;
   int    rr_g[6] = '{0, 1, 2, 0, 1, 2};

   comp_arb_pipe #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .DEPTH    (DEPTH)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .io_in_data      (io_in_data),
      .io_in_valid     (io_in_valid),
      .io_in_ready     (io_in_ready),
      .io_out_data     (io_out_data),
      .io_out_chan     (io_out_chan),
      .io_out_valid    (io_out_valid),
      .io_out_ready    (io_out_ready),
      .io_count        (io_count)
`ifdef COMP_ARB_PIPE_STATS_EN
      ,
      .io_stall_cycles (io_stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Output monitor: each output transfer must match the head of the scoreboard
   always @(negedge clock) begin
      if (!reset && io_out_valid && io_out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got chan %0d data 0x%0h, expected no word", io_out_chan, io_out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_chan", 32'(io_out_chan), 32'(mon_e.chan));
            check("out_data", 32'(io_out_data), 32'(mon_e.data));
         end
      end
   end

   // Watchdog
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with every producer valid to confirm ready stays low
      reset        = 1'b1;
      io_in_valid  = 3'b111;
      io_in_data   = {8'h12, 8'h11, 8'h10};
      io_out_ready = 1'b0;
      #12;
      check("rst_ready", 32'(io_in_ready), 32'h0);
      check("rst_out_valid", 32'(io_out_valid), 32'h0);
      check("rst_out_data", 32'(io_out_data), 32'h0);
      check("rst_out_chan", 32'(io_out_chan), 32'h0);
      check("rst_count", 32'(io_count), 32'h0);
      @(posedge clock);
      #1;
      reset       = 1'b0;
      io_in_valid = 3'b000;
      step();

      // Single word on channel 1
      io_in_data   = {8'h00, 8'h5A, 8'h00};
      io_in_valid  = 3'b010;
      io_out_ready = 1'b1;
      exp_q.push_back(word_t'{CW'(1), 8'h5A});
      #1;
      check("t1_ready", 32'(io_in_ready), 32'h2);
      step();
      io_in_valid = 3'b000;
      check("t1_out_valid", 32'(io_out_valid), 32'h1);
      check("t1_out_data", 32'(io_out_data), 32'h5A);
      check("t1_out_chan", 32'(io_out_chan), 32'h1);
      check("t1_count", 32'(io_count), 32'h1);
      step();
      check("t1_drained", 32'(io_count), 32'h0);

      // Fresh reset so channel 0 has first priority again
      reset = 1'b1;
      #2;
      reset = 1'b0;
      step();

      // Round-robin with all channels valid and the sink always ready
      io_in_data  = {8'h12, 8'h11, 8'h10};
      io_in_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(word_t'{CW'(rr_g[k]), WIDTH'(8'h10 + rr_g[k])});
         #1;
         check("rr_ready", 32'(io_in_ready), 32'(1) << rr_g[k]);
         step();
      end
      io_in_valid = 3'b000;
      step();
      step();
      check("rr_drained", 32'(io_count), 32'h0);

      // Fill the FIFO from channel 0 with the sink stalled
      io_out_ready = 1'b0;
      io_in_valid  = 3'b001;
      io_in_data   = {8'h00, 8'h00, 8'h01};
      exp_q.push_back(word_t'{CW'(0), 8'h01});
      #1;
      check("full_ready0", 32'(io_in_ready), 32'h1);
      step();
      io_in_data = {8'h00, 8'h00, 8'h02};
      exp_q.push_back(word_t'{CW'(0), 8'h02});
      #1;
      check("full_ready1", 32'(io_in_ready), 32'h1);
      step();
      io_in_data = {8'h00, 8'h00, 8'h03};
      #1;
      check("full_blocked", 32'(io_in_ready), 32'h0);
      check("full_count", 32'(io_count), 32'h2);
      step();
      check("full_blocked2", 32'(io_in_ready), 32'h0);
      step();
`ifdef COMP_ARB_PIPE_STATS_EN
      check("stall_cycles", 32'(io_stall_cycles), 32'h2);
`endif
      check("full_head", 32'(io_out_data), 32'h01);

      // Pop while full: no pass-through push that cycle
      io_out_ready = 1'b1;
      #1;
      check("pop_full_ready", 32'(io_in_ready), 32'h0);
      step();
      check("pop_full_count", 32'(io_count), 32'h1);

      // 0x03 accepted while 0x02 pops: count holds at 1
      exp_q.push_back(word_t'{CW'(0), 8'h03});
      #1;
      check("pp_ready", 32'(io_in_ready), 32'h1);
      step();
      check("pp_count", 32'(io_count), 32'h1);
      check("pp_head", 32'(io_out_data), 32'h03);

      // Ten more words streamed through to wrap the pointers repeatedly
      for (int k = 0; k < 10; k++) begin
         io_in_data = {8'h00, 8'h00, WIDTH'(8'h20 + k)};
         exp_q.push_back(word_t'{CW'(0), WIDTH'(8'h20 + k)});
         #1;
         check("wrap_ready", 32'(io_in_ready), 32'h1);
         step();
         check("wrap_count", 32'(io_count), 32'h1);
      end
      io_in_valid = 3'b000;
      step();
      step();
      check("wrap_drained", 32'(io_count), 32'h0);
      check("wrap_valid", 32'(io_out_valid), 32'h0);

      // Two words buffered on channel 1, then async reset mid-stream
      io_out_ready = 1'b0;
      io_in_valid  = 3'b010;
      io_in_data   = {8'h00, 8'h31, 8'h00};
      exp_q.push_back(word_t'{CW'(1), 8'h31});
      #1;
      check("ar_ready", 32'(io_in_ready), 32'h2);
      step();
      io_in_data = {8'h00, 8'h32, 8'h00};
      exp_q.push_back(word_t'{CW'(1), 8'h32});
      step();
      check("ar_count", 32'(io_count), 32'h2);
      #1;
      reset = 1'b1;
      #1;
      check("ar_out_valid", 32'(io_out_valid), 32'h0);
      check("ar_count0", 32'(io_count), 32'h0);
      check("ar_ready0", 32'(io_in_ready), 32'h0);
      exp_q.delete();
      io_in_valid = 3'b000;
      #2;
      reset = 1'b0;
      step();

      // After release, channel 2 alone is granted
      io_in_data   = {8'h77, 8'h00, 8'h00};
      io_in_valid  = 3'b100;
      io_out_ready = 1'b1;
      exp_q.push_back(word_t'{CW'(2), 8'h77});
      #1;
      check("post_ready", 32'(io_in_ready), 32'h4);
      step();
      io_in_valid = 3'b000;
      check("post_valid", 32'(io_out_valid), 32'h1);
      check("post_data", 32'(io_out_data), 32'h77);
      check("post_chan", 32'(io_out_chan), 32'h2);
      step();
      check("post_drained", 32'(io_count), 32'h0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
